control_merge_rr: RTL
=====================

# control_merge_rr

Buffered, arbitrated control merge for Handshake circuits. It accepts one token per cycle from SIZE input channels, each carrying DATA_TYPE bits, and records the winning input's index. The token and its index go into a SLOTS-deep FIFO. The FIFO head is presented on a data output channel and an index output channel through an eager two-way fork. This is the generalised merge-plus-index primitive for loop headers and mux select generation: it adds data payload, selectable fixed-priority or round-robin arbitration, and configurable buffering depth.

## Interface
- SIZE, 2: number of input channels, ≥ 2.
- DATA_TYPE, 32: payload width in bits, ≥ 1.
- INDEX_TYPE, 1: index width, ≥ ceil(log2(SIZE)).
- ARBITER, 0: 0 selects fixed priority (lowest valid index wins); 1 selects round-robin.
- SLOTS, 2: FIFO depth, ≥ 1. Any value is legal; power of two is not required.
- Synchronous, active-high reset; single clock `clk`.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ins  in  SIZE*DATA_TYPE  input payloads; input i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- ins_valid  in  SIZE  per-input valid.
- ins_ready  out  SIZE  per-input ready; at most one bit is high at a time.
- outs  out  DATA_TYPE  payload of the FIFO head.
- outs_valid  out  1  data channel valid.
- outs_ready  in  1  data channel ready.
- index  out  INDEX_TYPE  input number that produced the FIFO head.
- index_valid  out  1  index channel valid.
- index_ready  in  1  index channel ready.

## Operation
- State:
  - FIFO storage of SLOTS entries, each {payload, index}.
  - Head pointer, tail pointer and occupancy count (0..SLOTS).
  - Fork flags `sent_o` and `sent_i`.
  - Round-robin pointer `prio`, range 0..SIZE-1.
- Arbitration (combinational from ins_valid and prio only):
  - ARBITER=0: grant goes to the lowest i with ins_valid[i].
  - ARBITER=1: grant goes to the first valid i searching prio, prio+1, …, SIZE-1, 0, …, prio-1.
- Readiness: ins_ready[g] = granted[g] AND (count < SLOTS). It never depends on outs_ready or index_ready.
- Push: on any accepted transfer (ins_valid[g] & ins_ready[g]):
  - write {ins[g], g} at the tail;
  - advance the tail modulo SLOTS;
  - if ARBITER=1, set prio ← (g+1) mod SIZE. prio holds when there is no transfer.
- Head outputs:
  - outs and index are driven from the head entry.
  - outs_valid = (count>0) & !sent_o.
  - index_valid = (count>0) & !sent_i.
- Eager fork:
  - done_o = sent_o | (outs_valid & outs_ready); done_i is defined the same way for the index channel.
  - If done_o & done_i: pop the head, advance the head modulo SLOTS, clear both sent flags.
  - Otherwise: sent_o ← done_o and sent_i ← done_i.
- Push and pop in the same cycle: both take effect and count is unchanged. A full FIFO never pushes, even when it pops that cycle.
- Index value is zero-extended from g to INDEX_TYPE bits.
- Reset values:
  - count=0, head=tail=0, prio=0, sent_o=sent_i=0.
  - outs_valid=0, index_valid=0, ins_ready=0 for all inputs.
  - Storage is cleared, so outs and index read 0.
- Reset mid-operation: all buffered tokens and partial fork progress are discarded. No output is valid in the cycle after rst is sampled high.

## Timing
- Latency: a token accepted at edge N appears on outs/index, valid, from cycle N+1. There is no combinational input-to-output path.
- Throughput:
  - SLOTS ≥ 2 sustains 1 token per cycle with both consumers always ready.
  - SLOTS = 1 gives 1 token per 2 cycles.
- Combinational paths:
  - ins_valid → ins_ready (arbiter).
  - outs_ready/index_ready → internal pop only; they never reach ins_ready.
- Valid stability: once outs_valid or index_valid is high, the channel holds its value until accepted. rst is the only exception.
- A channel that has been consumed stays low until the head pops. No token is ever delivered twice on either channel.

## Test plan
- Reset and idle:
  - Hold rst for 2 cycles with all ins_valid=1 → ins_ready=0, outs_valid=0, index_valid=0.
  - Release rst → ins_ready=01 (SIZE=2, ARBITER=0).
  - Next cycle → outs=ins[0], index=0.
- Fixed priority, SIZE=4:
  - ins_valid=1110 held with consumers always ready → index sequence 1,1,1…
- Round-robin, SIZE=4, ARBITER=1:
  - ins_valid=1111 held → index sequence 0,1,2,3,0…
  - ins_valid=1010 held → 1,3,1,3…
- Eager fork, SLOTS=2:
  - index_ready=0 for 3 cycles while outs_ready=1 → data delivered exactly once.
  - Head does not pop and outs_valid=0 after the first transfer.
  - Raising index_ready pops the head.
- Full and back-pressure, SLOTS=3:
  - Both readies 0 with an input continuously valid → exactly 3 accepts, then ins_ready=0.
  - Enabling readies → 3 tokens drain in order; ins_ready rises the cycle after the first pop.
- Reset mid-stream: with 2 tokens buffered and sent_o=1, assert rst for 1 cycle → count=0, both valids 0, prio=0.

Source files
------------

// File: rtl/control_merge_rr.sv
// control_merge_rr: arbitrated merge of SIZE handshake inputs into a SLOTS-deep
// FIFO of {payload, winning index}. The FIFO head feeds a data channel and an
// index channel through an eager fork: each channel consumes the head once, and
// the head pops only after both channels have taken it.
module control_merge_rr #(
  parameter int SIZE       = 2,
  parameter int DATA_TYPE  = 32,
  parameter int INDEX_TYPE = 1,
  parameter int ARBITER    = 0,
  parameter int SLOTS      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic                      outs_valid,
  input  logic                      outs_ready,
  output logic [INDEX_TYPE-1:0]     index,
  output logic                      index_valid,
  input  logic                      index_ready
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
  localparam logic [PW-1:0] LAST_P  = PW'(SLOTS - 1);
  localparam logic [IW-1:0] LAST_I  = IW'(SIZE - 1);

  logic [DATA_TYPE-1:0]  mem_data [SLOTS];
  logic [INDEX_TYPE-1:0] mem_idx  [SLOTS];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic                  sent_o;
  logic                  sent_i;
  logic [IW-1:0]         prio;

  logic [IW-1:0]         gidx;
  logic                  any_valid;
  logic                  not_full;
  logic                  push;
  logic                  pop;
  logic                  done_o;
  logic                  done_i;

  // Arbiter: pick the winning input from ins_valid (and prio in round-robin mode).
  // Loops run from the far end so the first hit in search order is written last.
  always_comb begin
    gidx      = '0;
    any_valid = 1'b0;
    if (ARBITER == 0) begin
      for (int i = SIZE - 1; i >= 0; i--) begin
        if (ins_valid[i]) begin
          gidx      = IW'(i);
          any_valid = 1'b1;
        end
      end
    end else begin
      for (int k = SIZE - 1; k >= 0; k--) begin
        if (ins_valid[(int'(prio) + k) % SIZE]) begin
          gidx      = IW'((int'(prio) + k) % SIZE);
          any_valid = 1'b1;
        end
      end
    end
  end

  assign not_full = (count != SLOTS_C);
  // Readiness is held low during reset so nothing is accepted while rst is high.
  assign push     = any_valid & not_full & ~rst;

  // Grant the winner only when there is room; consumer readiness never reaches here.
  always_comb begin
    ins_ready = '0;
    if (push) ins_ready[gidx] = 1'b1;
  end

  assign outs        = mem_data[head];
  assign index       = mem_idx[head];
  assign outs_valid  = (count != '0) & ~sent_o;
  assign index_valid = (count != '0) & ~sent_i;
  assign done_o      = sent_o | (outs_valid & outs_ready);
  assign done_i      = sent_i | (index_valid & index_ready);
  assign pop         = done_o & done_i;

  // FIFO storage: cleared on reset so the head outputs read zero, written at tail on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
      end
    end else if (push) begin
      mem_data[tail] <= ins[int'(gidx)*DATA_TYPE +: DATA_TYPE];
      mem_idx[tail]  <= INDEX_TYPE'(gidx);
    end
  end

  // Pointers, occupancy, fork progress and round-robin priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      sent_o <= 1'b0;
      sent_i <= 1'b0;
      prio   <= '0;
    end else begin
      if (push) begin
        tail <= (tail == LAST_P) ? '0 : tail + 1'b1;
        if (ARBITER == 1) prio <= (gidx == LAST_I) ? '0 : gidx + 1'b1;
      end
      if (pop) begin
        head   <= (head == LAST_P) ? '0 : head + 1'b1;
        sent_o <= 1'b0;
        sent_i <= 1'b0;
      end else begin
        sent_o <= done_o;
        sent_i <= done_i;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
